// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble control for the 5-stage pipeline with multi-cycle EX FSM.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_multicycle,
  input  logic                  branch_taken,
  input  logic                  mem_stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  ex_mem_write,
  output logic                  mem_wb_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
);
  typedef enum logic {RUN, MC_BUSY} state_t;
  localparam int CW = $clog2(MC_LAT + 1);
  localparam bit MC_EN = MC_LAT > 1;
  localparam logic [CW-1:0] MC_INIT = CW'(MC_LAT > 1 ? MC_LAT - 2 : 0);
  state_t state;
  logic [CW-1:0] mc_cnt;
  logic busy, mc_enter, mc_last, load_use;
  always_comb begin
    busy = state == MC_BUSY;
    mc_enter = MC_EN && !busy && ex_multicycle;
    mc_last = busy && mc_cnt == '0;
    load_use = ex_mem_read && ex_rd != '0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b11111;
    {if_id_flush, id_ex_bubble, ex_mem_bubble, mc_busy, mc_done} = 5'b00000;
    if (!rst) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b00000;
      {if_id_flush, id_ex_bubble, ex_mem_bubble} = 3'b111;
    end else if (mem_stall) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b00000;
      mc_busy = busy;
    end else if (mc_enter || (busy && !mc_last)) begin
      {pc_write, if_id_write, id_ex_write} = 3'b000;
      ex_mem_bubble = 1'b1;
      mc_busy = 1'b1;
    end else if (mc_last) begin
      {mc_busy, mc_done} = 2'b11;
    end else if (branch_taken) begin
      {if_id_flush, id_ex_bubble} = 2'b11;
    end else if (load_use) begin
      {pc_write, if_id_write, id_ex_bubble} = 3'b001;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      mc_cnt <= '0;
    end else if (!mem_stall) begin
      if (mc_enter) begin
        state <= MC_BUSY;
        mc_cnt <= MC_INIT;
      end else if (busy) begin
        if (mc_last) state <= RUN;
        else mc_cnt <= mc_cnt - 1'b1;
      end
    end
  end
`ifdef HAZ_PERF_CNT_EN
  // A flush is only ever raised outside reset by a taken branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_write && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (if_id_flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int MC_LAT = 4;
  localparam int CNT_W = 32;
  logic clk = 0, rst = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_multicycle = 0, branch_taken = 0, mem_stall = 0;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_bubble, ex_mem_bubble, mc_busy, mc_done;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
  typedef struct packed {
    logic [9:0] ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int mc_rem = 0;
  logic [CNT_W-1:0] m_stall = 0, m_flush = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle),
    .branch_taken(branch_taken), .mem_stall(mem_stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mc_busy(mc_busy), .mc_done(mc_done), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // mc_rem counts EX cycles still owed to the multi-cycle op, including the current one.
  task automatic step(input logic r, ms, mc, br, mr, input logic [4:0] rd = 0, rs1 = 0, rs2 = 0,
                      input logic u1 = 0, u2 = 0);
    exp_t e;
    logic lu;
    rst = r; mem_stall = ms; ex_multicycle = mc; branch_taken = br; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!r) e.ctl = 10'b00000_111_00;
    else if (ms) e.ctl = {8'b0, mc_rem > 0, 1'b0};
    else if (mc_rem == 1) e.ctl = 10'b11111_000_11;
    else if (mc_rem > 1 || (mc && MC_LAT > 1)) e.ctl = 10'b00011_001_10;
    else if (br) e.ctl = 10'b11111_110_00;
    else if (lu) e.ctl = 10'b00111_010_00;
    else e.ctl = 10'b11111_000_00;
`ifdef HAZ_PERF_CNT_EN
    e.stall = m_stall; e.flush = m_flush;
`else
    e.stall = 0; e.flush = 0;
`endif
    q.push_back(e);
    if (!r) begin
      mc_rem = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e.ctl[9] && m_stall != '1) m_stall++;
      if (e.ctl[4] && m_flush != '1) m_flush++;
      if (!ms) begin
        if (mc_rem > 0) mc_rem--;
        else if (mc && MC_LAT > 1) mc_rem = MC_LAT - 1;
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e = q.pop_front();
      act = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
             if_id_flush, id_ex_bubble, ex_mem_bubble, mc_busy, mc_done};
      compared++;
      if (act !== e.ctl) begin
        mismatched++;
        $display("FAIL ctrl t=%0t got=%b exp=%b", $time, act, e.ctl);
      end
      compared++;
      if (perf_stall_cnt !== e.stall || perf_flush_cnt !== e.flush) begin
        mismatched++;
        $display("FAIL perf t=%0t got=%0d/%0d exp=%0d/%0d", $time, perf_stall_cnt, perf_flush_cnt, e.stall, e.flush);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 5, 5, 5, 1, 1);
    step(1, 0, 0, 0, 1, 5, 5, 0, 1, 0);
    step(1, 0, 0, 0, 0, 5, 5, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 7, 0, 7, 0, 1);
    step(1, 0, 0, 0, 1, 7, 7, 7, 0, 0);
    step(1, 0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 5, 5, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 3, 3, 3, 1, 1);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 2, 2, 2, 1, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) > 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 40, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    @(negedge clk); #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
